// File: rtl/sid_reg_write_rx.sv
// ---------------------------------------------------------------------------
// sid_reg_write_rx
//
// Receiving end of the SID register-write port. The host drives a write
// strobe, a voice/bank select, a register address and a data byte on the
// ui_in/uio_in pins. This block synchronises all of them together, detects
// each rising edge of the strobe and commits exactly one byte into the
// voice/filter register file. The register file feeds the oscillators,
// envelopes and filter of the SID core.
//
// Bus layout on ui_in_i: [7] we, [6:5] don't care, [4:3] voice (NUM_VOICES
// selects the filter bank), [2:0] register address. uio_in_i is the data.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   ui_in_i      {we, 2'bxx, voice[1:0], addr[2:0]}
//   uio_in_i     write data byte
//   freq_o       voice v frequency at [16v+15:16v] = {FREQ_HI, FREQ_LO}
//   pw_o         voice v pulse width at [12v+11:12v] = {PW_HI[3:0], PW_LO}
//   atk_dec_o    voice v attack/decay byte at [8v+7:8v]
//   sus_rel_o    voice v sustain/release byte at [8v+7:8v]
//   wav_o        voice v waveform/control byte at [8v+7:8v] (bit0 = gate)
//   fc_o         filter cutoff {FC_HI, FC_LO[2:0]}
//   res_filt_o   resonance[7:4] / filter enables[3:0]
//   mode_vol_o   filter mode[7:4] / master volume[3:0]
//   gate_on_o    one-cycle pulse per voice when a WAV write sets the gate
//   gate_off_o   one-cycle pulse per voice when a WAV write clears the gate
//   wr_strobe_o  one-cycle pulse for every accepted write, ignored
//                addresses included
// ---------------------------------------------------------------------------
module sid_reg_write_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int NUM_VOICES  = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [7:0]                ui_in_i,
  input  logic [7:0]                uio_in_i,
  output logic [16*NUM_VOICES-1:0]  freq_o,
  output logic [12*NUM_VOICES-1:0]  pw_o,
  output logic [8*NUM_VOICES-1:0]   atk_dec_o,
  output logic [8*NUM_VOICES-1:0]   sus_rel_o,
  output logic [8*NUM_VOICES-1:0]   wav_o,
  output logic [10:0]               fc_o,
  output logic [7:0]                res_filt_o,
  output logic [7:0]                mode_vol_o,
  output logic [NUM_VOICES-1:0]     gate_on_o,
  output logic [NUM_VOICES-1:0]     gate_off_o,
  output logic                      wr_strobe_o
);

  // Voice-bank register addresses
  localparam logic [2:0] ADDR_FREQ_LO = 3'd0;
  localparam logic [2:0] ADDR_FREQ_HI = 3'd1;
  localparam logic [2:0] ADDR_PW_LO   = 3'd2;
  localparam logic [2:0] ADDR_PW_HI   = 3'd3;
  localparam logic [2:0] ADDR_ATK     = 3'd4;
  localparam logic [2:0] ADDR_SUS     = 3'd5;
  localparam logic [2:0] ADDR_WAV     = 3'd6;

  // Filter-bank register addresses
  localparam logic [2:0] ADDR_FC_LO    = 3'd0;
  localparam logic [2:0] ADDR_FC_HI    = 3'd1;
  localparam logic [2:0] ADDR_RES_FILT = 3'd2;
  localparam logic [2:0] ADDR_MODE_VOL = 3'd3;

  // Bits carried through the synchroniser: {we, voice[1:0], addr[2:0], data[7:0]}
  localparam int SW = 14;

  // ui_in[6:5] carry nothing for this block
  logic unusedUiBits;
  assign unusedUiBits = &{1'b0, ui_in_i[6:5]};

  // ---------------------------------------------------------------------
  // Synchroniser and edge detector
  // ---------------------------------------------------------------------
  logic [SYNC_STAGES-1:0][SW-1:0] sync_q;
  logic                           weDly_q;
  logic [SW-1:0]                  syncTop;
  logic                           syncWe;
  logic [1:0]                     syncVoice;
  logic [2:0]                     syncAddr;
  logic [7:0]                     syncData;
  logic                           commit;

  // Strobe, address and data travel through the same flop chain so that
  // the address and data seen at the last stage are always those that
  // accompanied the strobe. weDly_q is one stage further on the strobe only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      weDly_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], {ui_in_i[7], ui_in_i[4:0], uio_in_i}};
      weDly_q <= syncWe;
    end
  end

  assign syncTop   = sync_q[SYNC_STAGES-1];
  assign syncWe    = syncTop[13];
  assign syncVoice = syncTop[12:11];
  assign syncAddr  = syncTop[10:8];
  assign syncData  = syncTop[7:0];

  // weDly_q clears on reset, so a strobe still high after reset release
  // counts as one fresh edge.
  assign commit = syncWe & ~weDly_q;

  // ---------------------------------------------------------------------
  // Register file state
  // ---------------------------------------------------------------------
  logic [7:0] freqLo_q [NUM_VOICES];
  logic [7:0] freqLo_d [NUM_VOICES];
  logic [7:0] freqHi_q [NUM_VOICES];
  logic [7:0] freqHi_d [NUM_VOICES];
  logic [7:0] pwLo_q   [NUM_VOICES];
  logic [7:0] pwLo_d   [NUM_VOICES];
  logic [3:0] pwHi_q   [NUM_VOICES];
  logic [3:0] pwHi_d   [NUM_VOICES];
  logic [7:0] atk_q    [NUM_VOICES];
  logic [7:0] atk_d    [NUM_VOICES];
  logic [7:0] sus_q    [NUM_VOICES];
  logic [7:0] sus_d    [NUM_VOICES];
  logic [7:0] wav_q    [NUM_VOICES];
  logic [7:0] wav_d    [NUM_VOICES];

  logic [2:0] fcLo_q, fcLo_d;
  logic [7:0] fcHi_q, fcHi_d;
  logic [7:0] resFilt_q, resFilt_d;
  logic [7:0] modeVol_q, modeVol_d;

  logic [NUM_VOICES-1:0] gateOn_q, gateOn_d;
  logic [NUM_VOICES-1:0] gateOff_q, gateOff_d;
  logic                  wrStrobe_q, wrStrobe_d;

  // Next-state decode. Each committed write touches at most one byte; the
  // multi-byte fields have no shadow latch, so a half-written frequency is
  // visible between writes just like on the real chip. Addresses without a
  // register still raise wr_strobe but change nothing.
  always_comb begin
    freqLo_d  = freqLo_q;
    freqHi_d  = freqHi_q;
    pwLo_d    = pwLo_q;
    pwHi_d    = pwHi_q;
    atk_d     = atk_q;
    sus_d     = sus_q;
    wav_d     = wav_q;
    fcLo_d    = fcLo_q;
    fcHi_d    = fcHi_q;
    resFilt_d = resFilt_q;
    modeVol_d = modeVol_q;
    gateOn_d  = '0;
    gateOff_d = '0;
    wrStrobe_d = commit;

    for (int v = 0; v < NUM_VOICES; v++) begin
      if (commit && (int'(syncVoice) == v)) begin
        case (syncAddr)
          ADDR_FREQ_LO: freqLo_d[v] = syncData;
          ADDR_FREQ_HI: freqHi_d[v] = syncData;
          ADDR_PW_LO:   pwLo_d[v]   = syncData;
          ADDR_PW_HI:   pwHi_d[v]   = syncData[3:0];
          ADDR_ATK:     atk_d[v]    = syncData;
          ADDR_SUS:     sus_d[v]    = syncData;
          ADDR_WAV: begin
            wav_d[v] = syncData;
            // Gate edges are judged against the value being replaced, so
            // rewriting the same gate level gives no pulse.
            gateOn_d[v]  = syncData[0] & ~wav_q[v][0];
            gateOff_d[v] = ~syncData[0] & wav_q[v][0];
          end
          default: ;
        endcase
      end
    end

    if (commit && (int'(syncVoice) == NUM_VOICES)) begin
      case (syncAddr)
        ADDR_FC_LO:    fcLo_d    = syncData[2:0];
        ADDR_FC_HI:    fcHi_d    = syncData;
        ADDR_RES_FILT: resFilt_d = syncData;
        ADDR_MODE_VOL: modeVol_d = syncData;
        default: ;
      endcase
    end
  end

  // All register-file contents and pulses are flopped, so no output has a
  // combinational path from the pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        freqLo_q[v] <= '0;
        freqHi_q[v] <= '0;
        pwLo_q[v]   <= '0;
        pwHi_q[v]   <= '0;
        atk_q[v]    <= '0;
        sus_q[v]    <= '0;
        wav_q[v]    <= '0;
      end
      fcLo_q     <= '0;
      fcHi_q     <= '0;
      resFilt_q  <= '0;
      modeVol_q  <= '0;
      gateOn_q   <= '0;
      gateOff_q  <= '0;
      wrStrobe_q <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        freqLo_q[v] <= freqLo_d[v];
        freqHi_q[v] <= freqHi_d[v];
        pwLo_q[v]   <= pwLo_d[v];
        pwHi_q[v]   <= pwHi_d[v];
        atk_q[v]    <= atk_d[v];
        sus_q[v]    <= sus_d[v];
        wav_q[v]    <= wav_d[v];
      end
      fcLo_q     <= fcLo_d;
      fcHi_q     <= fcHi_d;
      resFilt_q  <= resFilt_d;
      modeVol_q  <= modeVol_d;
      gateOn_q   <= gateOn_d;
      gateOff_q  <= gateOff_d;
      wrStrobe_q <= wrStrobe_d;
    end
  end

  // ---------------------------------------------------------------------
  // Output packing
  // ---------------------------------------------------------------------
  for (genvar v = 0; v < NUM_VOICES; v++) begin : gen_voice_out
    assign freq_o[16*v +: 16]  = {freqHi_q[v], freqLo_q[v]};
    assign pw_o[12*v +: 12]    = {pwHi_q[v], pwLo_q[v]};
    assign atk_dec_o[8*v +: 8] = atk_q[v];
    assign sus_rel_o[8*v +: 8] = sus_q[v];
    assign wav_o[8*v +: 8]     = wav_q[v];
  end

  assign fc_o        = {fcHi_q, fcLo_q};
  assign res_filt_o  = resFilt_q;
  assign mode_vol_o  = modeVol_q;
  assign gate_on_o   = gateOn_q;
  assign gate_off_o  = gateOff_q;
  assign wr_strobe_o = wrStrobe_q;

endmodule

// File: tb/tb_sid_reg_write_rx.sv
// ---------------------------------------------------------------------------
// tb_sid_reg_write_rx
//
// Bench for the SID register-write receiver. Each write driven on the bus
// updates a small register-file model and pushes the expected full output
// state onto a scoreboard; a monitor pops and compares it whenever the DUT
// raises wr_strobe.
// ---------------------------------------------------------------------------
module tb_sid_reg_write_rx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ui_in = 8'h00;
  logic [7:0]  uio_in = 8'h00;

  logic [47:0] freq;
  logic [35:0] pw;
  logic [23:0] atk_dec, sus_rel, wav;
  logic [10:0] fc;
  logic [7:0]  res_filt, mode_vol;
  logic [2:0]  gate_on, gate_off;
  logic        wr_strobe;

  int compareCount = 0;
  int mismatchCount = 0;
  int cycleCnt = 0;

  sid_reg_write_rx #(.SYNC_STAGES(2), .NUM_VOICES(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ui_in_i     (ui_in),
    .uio_in_i    (uio_in),
    .freq_o      (freq),
    .pw_o        (pw),
    .atk_dec_o   (atk_dec),
    .sus_rel_o   (sus_rel),
    .wav_o       (wav),
    .fc_o        (fc),
    .res_filt_o  (res_filt),
    .mode_vol_o  (mode_vol),
    .gate_on_o   (gate_on),
    .gate_off_o  (gate_off),
    .wr_strobe_o (wr_strobe)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  // Cycle counter used to time-stamp expected commits
  always @(posedge clk) cycleCnt++;

  logic anyOut;
  assign anyOut = |{freq, pw, atk_dec, sus_rel, wav, fc, res_filt, mode_vol,
                    gate_on, gate_off, wr_strobe};

  typedef struct {
    logic [47:0] freq;
    logic [35:0] pw;
    logic [23:0] atk;
    logic [23:0] sus;
    logic [23:0] wav;
    logic [10:0] fc;
    logic [7:0]  res;
    logic [7:0]  mode;
    logic [2:0]  gon;
    logic [2:0]  goff;
    int          cyc;
  } expect_t;

  expect_t scoreQ[$];
  expect_t monItem;

  // Register-file model
  logic [15:0] mFreq [3];
  logic [11:0] mPw   [3];
  logic [7:0]  mAtk  [3];
  logic [7:0]  mSus  [3];
  logic [7:0]  mWav  [3];
  logic [10:0] mFc;
  logic [7:0]  mRes, mMode;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int v = 0; v < 3; v++) begin
      mFreq[v] = '0; mPw[v] = '0; mAtk[v] = '0; mSus[v] = '0; mWav[v] = '0;
    end
    mFc = '0; mRes = '0; mMode = '0;
  endtask

  // Drives one write (caller is just after a posedge), updates the model,
  // queues the expected state and leaves the bus idle for a few cycles.
  task automatic applyStimulus(input int voice, input int addr,
                               input logic [7:0] data, input int hold);
    expect_t e;
    logic [2:0] gon = '0;
    logic [2:0] goff = '0;
    ui_in  = {1'b1, 2'($urandom_range(3)), 2'(voice), 3'(addr)};
    uio_in = data;
    if (voice < 3) begin
      case (addr)
        0: mFreq[voice][7:0]  = data;
        1: mFreq[voice][15:8] = data;
        2: mPw[voice][7:0]    = data;
        3: mPw[voice][11:8]   = data[3:0];
        4: mAtk[voice]        = data;
        5: mSus[voice]        = data;
        6: begin
          gon[voice]  = data[0] & ~mWav[voice][0];
          goff[voice] = ~data[0] & mWav[voice][0];
          mWav[voice] = data;
        end
        default: ;
      endcase
    end else begin
      case (addr)
        0: mFc[2:0]  = data[2:0];
        1: mFc[10:3] = data;
        2: mRes      = data;
        3: mMode     = data;
        default: ;
      endcase
    end
    for (int v = 0; v < 3; v++) begin
      e.freq[16*v +: 16] = mFreq[v];
      e.pw[12*v +: 12]   = mPw[v];
      e.atk[8*v +: 8]    = mAtk[v];
      e.sus[8*v +: 8]    = mSus[v];
      e.wav[8*v +: 8]    = mWav[v];
    end
    e.fc = mFc; e.res = mRes; e.mode = mMode;
    e.gon = gon; e.goff = goff;
    // sampled at next posedge (cycle 0), visible after posedge 2
    e.cyc = cycleCnt + 3;
    scoreQ.push_back(e);
    repeat (hold) @(posedge clk);
    #1;
    ui_in[7] = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Monitor: compare the whole register file when a write is reported
  always @(negedge clk) begin
    if (wr_strobe) begin
      if (scoreQ.size() == 0) begin
        checkOutput("unexpected_strobe", 64'd1, 64'd0);
      end else begin
        monItem = scoreQ.pop_front();
        checkOutput("strobe_cycle", 64'(cycleCnt), 64'(monItem.cyc));
        checkOutput("freq",     64'(freq),     64'(monItem.freq));
        checkOutput("pw",       64'(pw),       64'(monItem.pw));
        checkOutput("atk_dec",  64'(atk_dec),  64'(monItem.atk));
        checkOutput("sus_rel",  64'(sus_rel),  64'(monItem.sus));
        checkOutput("wav",      64'(wav),      64'(monItem.wav));
        checkOutput("fc",       64'(fc),       64'(monItem.fc));
        checkOutput("res_filt", 64'(res_filt), 64'(monItem.res));
        checkOutput("mode_vol", 64'(mode_vol), 64'(monItem.mode));
        checkOutput("gate_on",  64'(gate_on),  64'(monItem.gon));
        checkOutput("gate_off", 64'(gate_off), 64'(monItem.goff));
      end
    end else if (gate_on !== 3'b000 || gate_off !== 3'b000) begin
      checkOutput("stray_gate", 64'({gate_on, gate_off}), 64'd0);
    end
  end

  initial begin
    modelReset();

    // Reset and idle
    repeat (3) @(posedge clk);
    #1;
    checkOutput("in_reset", 64'(anyOut), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("idle_out", 64'(anyOut), 64'd0);
    end

    // Frequency low then high byte, single-cycle strobes
    applyStimulus(0, 0, 8'h24, 1);
    applyStimulus(0, 1, 8'h00, 1);
    checkOutput("freq_v0", 64'(freq[15:0]), 64'h0024);

    // Strobe held for 10 cycles, upper pulse-width nibble dropped
    applyStimulus(1, 3, 8'hF8, 10);
    checkOutput("pw_v1", 64'(pw[23:12]), 64'h800);
    applyStimulus(2, 4, 8'h5A, 2);
    applyStimulus(1, 5, 8'hC3, 1);
    applyStimulus(2, 2, 8'h7E, 3);

    // Filter bank and ignored addresses
    applyStimulus(3, 1, 8'h20, 1);
    applyStimulus(3, 0, 8'h07, 1);
    applyStimulus(3, 3, 8'h4F, 1);
    applyStimulus(3, 2, 8'hF1, 1);
    applyStimulus(0, 7, 8'hFF, 1);
    applyStimulus(3, 5, 8'hAA, 1);
    checkOutput("fc_value", 64'(fc), 64'h107);
    checkOutput("mode_vol_value", 64'(mode_vol), 64'h4F);

    // Gate edges on voice 2
    applyStimulus(2, 6, 8'h21, 1);
    applyStimulus(2, 6, 8'h21, 1);
    applyStimulus(2, 6, 8'h20, 1);
    applyStimulus(0, 6, 8'h41, 1);

    // Reset one cycle into a transfer: the write is lost
    ui_in  = {1'b1, 2'b00, 2'd0, 3'd2};
    uio_in = 8'h99;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    ui_in[7] = 1'b0;
    #1;
    checkOutput("async_clear", 64'(anyOut), 64'd0);
    modelReset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("no_commit_after_reset", 64'(anyOut), 64'd0);

    // Clean write after reset
    applyStimulus(0, 0, 8'h5A, 1);
    checkOutput("freq_after_reset", 64'(freq), 64'h5A);

    repeat (4) @(posedge clk);
    #1;
    checkOutput("queue_empty", 64'(scoreQ.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
